// File: rtl/i2s_master_pkg.sv
// Shared constants for the I2S master: word width, frame length and slot map.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: word_t and slot_t types, slot positions of left/right MSB and LSB,
//           next_slot() helper for the free-running slot counter.
package i2s_master_pkg;

  localparam int I2S_WORD_W     = 16;
  localparam int I2S_FRAME_BCLK = 32;
  localparam int SLOT_W         = $clog2(I2S_FRAME_BCLK);

  typedef logic [I2S_WORD_W-1:0] word_t;
  typedef logic [SLOT_W-1:0]     slot_t;

  // One-BCLK-delayed I2S: each word starts one slot after LRCLK changes,
  // so the right LSB lands in slot 0 of the following frame.
  localparam slot_t SLOT_L_MSB = slot_t'(1);
  localparam slot_t SLOT_L_LSB = slot_t'(16);
  localparam slot_t SLOT_R_MSB = slot_t'(17);
  localparam slot_t SLOT_R_LSB = slot_t'(0);
  localparam slot_t SLOT_LAST  = slot_t'(I2S_FRAME_BCLK - 1);

  // Slot counter wraps naturally at the frame length (power of two).
  function automatic slot_t next_slot(input slot_t s);
    return s + slot_t'(1);
  endfunction

endpackage

// File: rtl/i2s_master.sv
// Stereo 16-bit I2S master clocked by BCLK: LRCLK generation, TX serializer, RX deserializer.
// Latency: left word out after slot 16 rising edge, right word after slot 0 rising edge (next frame).
// Backpressure: none; free-running link, parallel inputs sampled at load slots, outputs held until next word.
// Ports:
//   i2s_bclk, reset            bit clock (only clock) and synchronous active-high reset
//   i2s_lrclk, i2s_sdout       word select (0 = left) and serial data to codec, change on falling edges
//   i2s_sdin                   serial data from codec, sampled on rising edges
//   left/right_data_in         parallel words to transmit
//   left/right_data_out        last complete words received
module i2s_master
  import i2s_master_pkg::*;
(
  input  logic                  i2s_bclk,
  input  logic                  reset,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdout,
  input  logic                  i2s_sdin,
  output logic [I2S_WORD_W-1:0] left_data_out,
  output logic [I2S_WORD_W-1:0] right_data_out,
  input  logic [I2S_WORD_W-1:0] left_data_in,
  input  logic [I2S_WORD_W-1:0] right_data_in
);

  slot_t cnt;
  slot_t cnt_nxt;

  // TX holds only the bits not yet driven; the MSB goes straight to SDOUT
  // at the load edge, so 15 bits of storage suffice.
  logic [I2S_WORD_W-2:0] tx_rem;

  // RX keeps the previous 15 bits; together with the live SDIN bit they
  // form the complete word at the capture edge.
  logic [I2S_WORD_W-2:0] rx_sr;
  word_t                 rx_word;

  // Blocks the right-word capture at the first slot 0 after reset, which
  // would otherwise latch a word whose first half was never received.
  logic rx_armed;

  assign cnt_nxt = next_slot(cnt);
  assign rx_word = {rx_sr, i2s_sdin};

  // Falling edge: slot counter, LRCLK and transmit path.
  always_ff @(negedge i2s_bclk) begin
    if (reset) begin
      cnt       <= SLOT_LAST;
      i2s_lrclk <= 1'b1;
      i2s_sdout <= 1'b0;
      tx_rem    <= '0;
    end else begin
      cnt       <= cnt_nxt;
      // LRCLK tracks the slot being entered, so it flips on the same edge
      // as the counter moves into slot 0 or 16.
      i2s_lrclk <= cnt_nxt[SLOT_W-1];
      if (cnt_nxt == SLOT_L_MSB) begin
        {i2s_sdout, tx_rem} <= left_data_in;
      end else if (cnt_nxt == SLOT_R_MSB) begin
        {i2s_sdout, tx_rem} <= right_data_in;
      end else begin
        i2s_sdout <= tx_rem[I2S_WORD_W-2];
        tx_rem    <= {tx_rem[I2S_WORD_W-3:0], 1'b0};
      end
    end
  end

  // Rising edge: mid-bit sampling of SDIN and word capture. cnt is stable
  // here because it only changes on falling edges.
  always_ff @(posedge i2s_bclk) begin
    if (reset) begin
      rx_sr          <= '0;
      rx_armed       <= 1'b0;
      left_data_out  <= '0;
      right_data_out <= '0;
    end else begin
      rx_sr <= rx_word[I2S_WORD_W-2:0];
      if (cnt == SLOT_L_LSB) begin
        left_data_out <= rx_word;
      end
      if (cnt == SLOT_R_MSB) begin
        rx_armed <= 1'b1;
      end
      if ((cnt == SLOT_R_LSB) && rx_armed) begin
        right_data_out <= rx_word;
      end
    end
  end

endmodule

// File: tb/tb_i2s_master.sv
// Self-checking bench for i2s_master against a slot-level behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2s_master;

  logic        i2s_bclk = 1'b0;
  logic        reset    = 1'b1;
  logic        i2s_lrclk;
  logic        i2s_sdout;
  logic        i2s_sdin;
  logic [15:0] left_data_out;
  logic [15:0] right_data_out;
  logic [15:0] left_data_in  = 16'h0000;
  logic [15:0] right_data_in = 16'h0000;

  logic sdin_drv = 1'b0;
  logic loop_en  = 1'b0;

  assign i2s_sdin = loop_en ? i2s_sdout : sdin_drv;

  i2s_master dut (
    .i2s_bclk       (i2s_bclk),
    .reset          (reset),
    .i2s_lrclk      (i2s_lrclk),
    .i2s_sdout      (i2s_sdout),
    .i2s_sdin       (i2s_sdin),
    .left_data_out  (left_data_out),
    .right_data_out (right_data_out),
    .left_data_in   (left_data_in),
    .right_data_in  (right_data_in)
  );

  always #5 i2s_bclk = ~i2s_bclk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: current slot, words being sent, words the
  // codec side is sending, and the outputs the DUT should show.
  int          slot      = 31;
  logic [15:0] tx_l      = 16'h0;
  logic [15:0] tx_r      = 16'h0;
  logic [15:0] rx_l      = 16'h0;
  logic [15:0] rx_r      = 16'h0;
  logic [15:0] exp_lo    = 16'h0;
  logic [15:0] exp_ro    = 16'h0;
  logic        exp_sdout = 1'b0;
  logic        exp_lrclk = 1'b1;
  logic        seen17    = 1'b0;
  logic        rand_rx   = 1'b0;
  logic        bits     [32];
  logic        obs_bits [32];

  // Advance one BCLK: wait for a falling edge, settle, then update the model
  // from the slot rules and drive the codec-side SDIN bit for the new slot.
  task automatic tick();
    logic [15:0] w;
    @(negedge i2s_bclk);
    #2;
    if (reset) begin
      slot      = 31;
      exp_lrclk = 1'b1;
      exp_sdout = 1'b0;
      tx_r      = 16'h0;
      exp_lo    = 16'h0;
      exp_ro    = 16'h0;
      seen17    = 1'b0;
    end else begin
      // Words completed during the slot just left.
      if (slot == 16) begin
        w = 16'h0;
        for (int i = 1; i <= 16; i++) w = {w[14:0], bits[i]};
        exp_lo = w;
      end
      if (slot == 0 && seen17) begin
        w = 16'h0;
        for (int i = 17; i <= 31; i++) w = {w[14:0], bits[i]};
        w = {w[14:0], bits[0]};
        exp_ro = w;
      end
      slot = (slot + 1) % 32;
      if (slot == 1) tx_l = left_data_in;
      if (slot == 17) begin
        tx_r   = right_data_in;
        seen17 = 1'b1;
      end
      if (slot >= 1 && slot <= 16)  exp_sdout = tx_l[4'(16 - slot)];
      else if (slot >= 17)          exp_sdout = tx_r[4'(32 - slot)];
      else                          exp_sdout = tx_r[0];
      exp_lrclk = (slot >= 16);
    end
    if (rand_rx && slot == 1)  rx_l = 16'($urandom);
    if (rand_rx && slot == 17) rx_r = 16'($urandom);
    if (slot >= 1 && slot <= 16) sdin_drv = rx_l[4'(16 - slot)];
    else if (slot >= 17)         sdin_drv = rx_r[4'(32 - slot)];
    else                         sdin_drv = rx_r[0];
    bits[slot]     = loop_en ? exp_sdout : sdin_drv;
    obs_bits[slot] = i2s_sdout;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (i2s_lrclk !== 1'b1) begin failures++; $display("FAIL reset_lrclk got=%b exp=1", i2s_lrclk); end
    checks++; if (i2s_sdout !== 1'b0) begin failures++; $display("FAIL reset_sdout got=%b exp=0", i2s_sdout); end
    checks++; if (left_data_out !== 16'h0000) begin failures++; $display("FAIL reset_left got=%h exp=0000", left_data_out); end
    checks++; if (right_data_out !== 16'h0000) begin failures++; $display("FAIL reset_right got=%h exp=0000", right_data_out); end
  endtask

  task automatic test_tx_lr();
    int last_fall = -1;
    int highs     = 0;
    logic prev_lr = 1'b1;
    left_data_in  = 16'h55AA;
    right_data_in = 16'hAA55;
    reset = 1'b0;
    for (int n = 0; n < 96; n++) begin
      tick();
      checks++; if (i2s_sdout !== exp_sdout) begin failures++; $display("FAIL tx_sdout slot=%0d got=%b exp=%b", slot, i2s_sdout, exp_sdout); end
      checks++; if (i2s_lrclk !== exp_lrclk) begin failures++; $display("FAIL tx_lrclk slot=%0d got=%b exp=%b", slot, i2s_lrclk, exp_lrclk); end
      if (n == 0) begin
        checks++; if (i2s_lrclk !== 1'b0) begin failures++; $display("FAIL first_lrclk_fall got=%b exp=0", i2s_lrclk); end
      end
      if (prev_lr === 1'b1 && i2s_lrclk === 1'b0) begin
        if (last_fall >= 0) begin
          checks++; if (n - last_fall != 32) begin failures++; $display("FAIL lrclk_period got=%0d exp=32", n - last_fall); end
        end
        last_fall = n;
      end
      if (n >= 32 && n < 64 && i2s_lrclk === 1'b1) highs++;
      prev_lr = i2s_lrclk;
    end
    checks++; if (highs != 16) begin failures++; $display("FAIL lrclk_duty high=%0d exp=16", highs); end
  endtask

  task automatic test_midframe_change();
    int nl = 0;
    int nr = 0;
    logic r_changed = 1'b0;
    logic [15:0] w;
    for (int n = 0; n < 32 && slot != 5; n++) tick();
    left_data_in = 16'h1111;
    for (int n = 0; n < 64; n++) begin
      tick();
      checks++; if (i2s_sdout !== exp_sdout) begin failures++; $display("FAIL mid_sdout slot=%0d got=%b exp=%b", slot, i2s_sdout, exp_sdout); end
      if (slot == 20 && !r_changed) begin
        right_data_in = 16'h7777;
        r_changed = 1'b1;
      end
      if (slot == 16 && nl < 2) begin
        w = 16'h0;
        for (int i = 1; i <= 16; i++) w = {w[14:0], obs_bits[i]};
        checks++;
        if (w !== (nl == 0 ? 16'h55AA : 16'h1111)) begin
          failures++; $display("FAIL mid_left_word frame=%0d got=%h exp=%h", nl, w, (nl == 0 ? 16'h55AA : 16'h1111));
        end
        nl++;
      end
      if (slot == 0 && r_changed && nr < 2) begin
        w = 16'h0;
        for (int i = 17; i <= 31; i++) w = {w[14:0], obs_bits[i]};
        w = {w[14:0], obs_bits[0]};
        checks++;
        if (w !== (nr == 0 ? 16'hAA55 : 16'h7777)) begin
          failures++; $display("FAIL mid_right_word frame=%0d got=%h exp=%h", nr, w, (nr == 0 ? 16'hAA55 : 16'h7777));
        end
        nr++;
      end
    end
    checks++; if (nl != 2 || nr != 2) begin failures++; $display("FAIL mid_word_count got=%0d/%0d exp=2/2", nl, nr); end
  endtask

  task automatic test_loopback();
    loop_en       = 1'b1;
    left_data_in  = 16'h1234;
    right_data_in = 16'hFEDC;
    for (int n = 0; n < 96; n++) begin
      tick();
      checks++; if (i2s_sdout !== exp_sdout) begin failures++; $display("FAIL loop_sdout slot=%0d got=%b exp=%b", slot, i2s_sdout, exp_sdout); end
      checks++; if (left_data_out !== exp_lo) begin failures++; $display("FAIL loop_left slot=%0d got=%h exp=%h", slot, left_data_out, exp_lo); end
      checks++; if (right_data_out !== exp_ro) begin failures++; $display("FAIL loop_right slot=%0d got=%h exp=%h", slot, right_data_out, exp_ro); end
    end
    checks++; if (left_data_out !== 16'h1234) begin failures++; $display("FAIL loop_left_final got=%h exp=1234", left_data_out); end
    checks++; if (right_data_out !== 16'hFEDC) begin failures++; $display("FAIL loop_right_final got=%h exp=fedc", right_data_out); end
    loop_en = 1'b0;
  endtask

  task automatic test_sdin_zero();
    rx_l = 16'h0;
    rx_r = 16'h0;
    reset = 1'b1;
    tick();
    tick();
    left_data_in  = 16'($urandom);
    right_data_in = 16'($urandom);
    reset = 1'b0;
    for (int n = 0; n < 96; n++) begin
      tick();
      checks++; if (left_data_out !== 16'h0000) begin failures++; $display("FAIL zero_left slot=%0d got=%h exp=0000", slot, left_data_out); end
      checks++; if (right_data_out !== 16'h0000) begin failures++; $display("FAIL zero_right slot=%0d got=%h exp=0000", slot, right_data_out); end
      checks++; if (i2s_sdout !== exp_sdout) begin failures++; $display("FAIL zero_sdout slot=%0d got=%b exp=%b", slot, i2s_sdout, exp_sdout); end
    end
  endtask

  task automatic test_random();
    rand_rx = 1'b1;
    for (int n = 0; n < 128; n++) begin
      tick();
      checks++; if (i2s_sdout !== exp_sdout) begin failures++; $display("FAIL rnd_sdout slot=%0d got=%b exp=%b", slot, i2s_sdout, exp_sdout); end
      checks++; if (i2s_lrclk !== exp_lrclk) begin failures++; $display("FAIL rnd_lrclk slot=%0d got=%b exp=%b", slot, i2s_lrclk, exp_lrclk); end
      checks++; if (left_data_out !== exp_lo) begin failures++; $display("FAIL rnd_left slot=%0d got=%h exp=%h", slot, left_data_out, exp_lo); end
      checks++; if (right_data_out !== exp_ro) begin failures++; $display("FAIL rnd_right slot=%0d got=%h exp=%h", slot, right_data_out, exp_ro); end
      if ($urandom_range(0, 7) == 0) left_data_in  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) right_data_in = 16'($urandom);
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 32 && slot != 10; n++) tick();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (i2s_lrclk !== 1'b1) begin failures++; $display("FAIL rmid_lrclk got=%b exp=1", i2s_lrclk); end
    checks++; if (i2s_sdout !== 1'b0) begin failures++; $display("FAIL rmid_sdout got=%b exp=0", i2s_sdout); end
    checks++; if (left_data_out !== 16'h0000) begin failures++; $display("FAIL rmid_left got=%h exp=0000", left_data_out); end
    checks++; if (right_data_out !== 16'h0000) begin failures++; $display("FAIL rmid_right got=%h exp=0000", right_data_out); end
    reset = 1'b0;
    tick();
    checks++; if (i2s_lrclk !== 1'b0) begin failures++; $display("FAIL rmid_restart_lrclk got=%b exp=0", i2s_lrclk); end
    tick();
    // Slot 0 right after release must not produce a right word.
    checks++; if (right_data_out !== 16'h0000) begin failures++; $display("FAIL rmid_no_right got=%h exp=0000", right_data_out); end
    for (int n = 0; n < 64; n++) begin
      tick();
      checks++; if (i2s_sdout !== exp_sdout) begin failures++; $display("FAIL rmid_sdout slot=%0d got=%b exp=%b", slot, i2s_sdout, exp_sdout); end
      checks++; if (i2s_lrclk !== exp_lrclk) begin failures++; $display("FAIL rmid_lrclk_run slot=%0d got=%b exp=%b", slot, i2s_lrclk, exp_lrclk); end
      checks++; if (left_data_out !== exp_lo) begin failures++; $display("FAIL rmid_left_run slot=%0d got=%h exp=%h", slot, left_data_out, exp_lo); end
      checks++; if (right_data_out !== exp_ro) begin failures++; $display("FAIL rmid_right_run slot=%0d got=%h exp=%h", slot, right_data_out, exp_ro); end
    end
    rand_rx = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      bits[i]     = 1'b0;
      obs_bits[i] = 1'b0;
    end
    test_reset();
    test_tx_lr();
    test_midframe_change();
    test_loopback();
    test_sdin_zero();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
